rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
Parametrised, registered N-to-log2(N) encoder with rotating (round-robin) priority and a valid/ready output handshake. It replaces the fixed 4-to-2 priority encoder wherever multiple requesters share one downstream consumer and fairness is required. A winning request is captured into an output register and held stable until the consumer accepts it.

Parameters:
N, 8, number of request lines; legal range 2..64.
IDX_W, 3, width of the encoded index; must equal ceil(log2(N)).

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
req  input  N  request vector; any number of bits may be set; sampled only in IDLE or on an accept cycle
out_ready  input  1  consumer accepts the current grant when high together with out_valid
out_valid  output  1  a grant is held in the output register
out_idx  output  IDX_W  binary index of the granted request
out_onehot  output  N  one-hot form of out_idx; all zero when out_valid=0
out_multi  output  1  more than one req bit was set when the grant was captured

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_idx=0, out_onehot=0, out_multi=0, ptr=0, state=IDLE. Reset asserted mid-grant drops the pending grant; nothing is replayed after release.
- ptr (IDX_W bits, internal) is the highest-priority index. The search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- Winner: the first set bit of req in search order. Computed combinationally and registered; latency is exactly 1 cycle from req sampling to out_valid.
- State IDLE, out_valid=0:
  - If req!=0: capture the winner into out_idx/out_onehot, set out_multi=(popcount(req)>1) and out_valid=1, and go to HOLD.
  - If req==0: stay in IDLE; outputs unchanged except out_onehot=0.
- State HOLD, out_valid=1:
  - While out_ready=0: out_idx, out_onehot and out_multi are held bit-stable, even if req changes or the granted bit drops. ptr is unchanged.
  - Accept (out_valid & out_ready): ptr <= out_idx+1, wrapping to 0 when out_idx==N-1 (N not a power of two wraps at N-1, not 2^IDX_W-1).
  - Same accept cycle: if req!=0, capture the next winner using the updated ptr (back-to-back, one grant per cycle, out_valid stays 1). Otherwise clear out_valid and out_onehot and return to IDLE.
- The bit that was just granted is eligible again, but at lowest priority.
- out_ready while out_valid=0 is ignored.
- Pure combinational search; no multi-cycle scan for any legal N.

Optional Feature:
FIXED_PRIORITY_EN: when defined, ptr is tied to 0 and not updated, and the search is highest index first (N-1 down to 0), matching legacy fixed-priority encoder semantics; the handshake and out_multi are unchanged. When undefined, round-robin as above.

Test Plan:
- Reset: assert rst mid-HOLD with out_idx=5 -> out_valid, out_idx, out_onehot and out_multi all 0 immediately (asynchronous); the first grant after release starts from ptr=0.
- Single request: req=8'b0001_0000 in IDLE -> next cycle out_valid=1, out_idx=4, out_onehot=8'h10, out_multi=0.
- Fairness: req=8'hFF held, out_ready=1 -> out_idx sequence 0,1,2,...,7,0 on consecutive cycles with out_valid continuously 1 and out_multi=1.
- Backpressure: capture idx 2 from req=8'h0C, then out_ready=0 for 5 cycles while req changes to 8'h01 -> outputs frozen at idx 2 and out_multi=1; on out_ready=1 the next grant is idx 0 (search wraps 3..7 then 0).
- Wrap with N=5, IDX_W=3: grant idx 4 accepted with req=5'b10001 -> ptr wraps to 0 and the next grant is idx 0, not 4.
- FIXED_PRIORITY_EN build: req=8'b1010_0110 held, out_ready=1 -> out_idx=7 every cycle, never rotates.

Source files
------------

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
//   Registered N-to-IDX_W encoder with rotating (round-robin) priority and a
//   valid/ready output handshake. A winner is captured one cycle after req is
//   sampled and held bit-stable until the consumer accepts it. On an accept
//   with req still non-zero, the next winner (searched from the updated
//   pointer) is captured in the same cycle, giving one grant per cycle.
//
//   Optional build macro: FIXED_PRIORITY_EN
//     Defined   -> no rotation; the search is highest index first (N-1..0).
//     Undefined -> round-robin starting at ptr; ptr moves to granted+1.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req        : N-bit request vector (sampled in IDLE or on an accept cycle)
//   out_ready  : consumer accepts the current grant when high with out_valid
//   out_valid  : a grant is held in the output register
//   out_idx    : binary index of the granted request
//   out_onehot : one-hot form of out_idx, zero whenever out_valid is low
//   out_multi  : more than one req bit was set when the grant was captured
module rr_priority_encoder #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             out_multi
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [N-1:0]     r_onehot, w_onehot_nxt;
    logic             r_multi, w_multi_nxt;

    logic             w_win_found;
    logic [IDX_W-1:0] w_win_idx;
    logic [N-1:0]     w_win_oh;
    logic             w_req_multi;

`ifdef FIXED_PRIORITY_EN
    // Legacy fixed priority: highest set index wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_win_found && req[N-1-i]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDX_W'(N-1-i);
            end
        end
    end
`else
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_inc;
    logic [IDX_W-1:0] w_search_ptr;
    logic             w_accept;

    // Modulo-N add; wraps at N, not at 2**IDX_W, so non-power-of-two N works.
    function automatic logic [IDX_W-1:0] f_wrap_add(input logic [IDX_W-1:0] base,
                                                    input int unsigned       off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    assign w_accept     = (r_state == S_HOLD) && out_ready;
    assign w_ptr_inc    = (r_idx == IDX_W'(N-1)) ? '0 : r_idx + 1'b1;
    // On an accept the back-to-back search must already use the advanced ptr.
    assign w_search_ptr = w_accept ? w_ptr_inc : r_ptr;

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_win_found && req[f_wrap_add(w_search_ptr, i)]) begin
                w_win_found = 1'b1;
                w_win_idx   = f_wrap_add(w_search_ptr, i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_inc;
        end
    end
`endif

    assign w_win_oh    = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
    // Clearing the lowest set bit leaves something only if popcount > 1.
    assign w_req_multi = (req & (req - N'(1))) != '0;

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_onehot_nxt = r_onehot;
        w_multi_nxt  = r_multi;
        unique case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt  = S_HOLD;
                    w_idx_nxt    = w_win_idx;
                    w_onehot_nxt = w_win_oh;
                    w_multi_nxt  = w_req_multi;
                end else begin
                    w_onehot_nxt = '0;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (w_win_found) begin
                        w_idx_nxt    = w_win_idx;
                        w_onehot_nxt = w_win_oh;
                        w_multi_nxt  = w_req_multi;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_onehot_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_onehot <= '0;
            r_multi  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_onehot <= w_onehot_nxt;
            r_multi  <= w_multi_nxt;
        end
    end

    assign out_valid  = (r_state == S_HOLD);
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign out_multi  = r_multi;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: an N=8 instance for the main
// behaviour and an N=5 instance for the non-power-of-two pointer wrap.
// Build with FIXED_PRIORITY_EN defined to exercise the fixed-priority mode.
module tb_rr_priority_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] req = '0;
    logic       rdy = 1'b0;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       multi;

    logic [4:0] req5 = '0;
    logic       rdy5 = 1'b0;
    logic       vld5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    logic       multi5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_priority_encoder #(.N(8), .IDX_W(3)) u_dut8 (
        .clk(clk), .rst(rst), .req(req), .out_ready(rdy),
        .out_valid(vld), .out_idx(idx), .out_onehot(oh), .out_multi(multi)
    );

    rr_priority_encoder #(.N(5), .IDX_W(3)) u_dut5 (
        .clk(clk), .rst(rst), .req(req5), .out_ready(rdy5),
        .out_valid(vld5), .out_idx(idx5), .out_onehot(oh5), .out_multi(multi5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; rdy = 1'b0; req5 = '0; rdy5 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (vld !== 1'b0)   begin n_err++; $display("FAIL reset_valid got=%0b exp=0", vld); end
        n_cmp++; if (idx !== 3'd0)   begin n_err++; $display("FAIL reset_idx got=%0d exp=0", idx); end
        n_cmp++; if (oh !== 8'h00)   begin n_err++; $display("FAIL reset_onehot got=%h exp=00", oh); end
        n_cmp++; if (multi !== 1'b0) begin n_err++; $display("FAIL reset_multi got=%0b exp=0", multi); end
        n_cmp++; if (vld5 !== 1'b0)  begin n_err++; $display("FAIL reset_valid5 got=%0b exp=0", vld5); end
        // idle with no request stays idle
        tick();
        n_cmp++; if (vld !== 1'b0)   begin n_err++; $display("FAIL idle_noreq_valid got=%0b exp=0", vld); end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'b0001_0000;
        tick();
        n_cmp++; if (vld !== 1'b1)   begin n_err++; $display("FAIL single_valid got=%0b exp=1", vld); end
        n_cmp++; if (idx !== 3'd4)   begin n_err++; $display("FAIL single_idx got=%0d exp=4", idx); end
        n_cmp++; if (oh !== 8'h10)   begin n_err++; $display("FAIL single_onehot got=%h exp=10", oh); end
        n_cmp++; if (multi !== 1'b0) begin n_err++; $display("FAIL single_multi got=%0b exp=0", multi); end
        // accept with no further request: back to idle, index retained
        rdy = 1'b1; req = '0;
        tick();
        n_cmp++; if (vld !== 1'b0)   begin n_err++; $display("FAIL single_drop_valid got=%0b exp=0", vld); end
        n_cmp++; if (oh !== 8'h00)   begin n_err++; $display("FAIL single_drop_onehot got=%h exp=00", oh); end
        n_cmp++; if (idx !== 3'd4)   begin n_err++; $display("FAIL single_drop_idx got=%0d exp=4", idx); end
        rdy = 1'b0;
    endtask

    task automatic test_fairness();
        logic [2:0] e;
        do_reset();
        req = 8'hFF; rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            e = 3'(i % 8);
            n_cmp++; if (vld !== 1'b1)   begin n_err++; $display("FAIL fair_valid[%0d] got=%0b exp=1", i, vld); end
            n_cmp++; if (idx !== e)      begin n_err++; $display("FAIL fair_idx[%0d] got=%0d exp=%0d", i, idx, e); end
            n_cmp++; if (oh !== (8'h01 << e)) begin n_err++; $display("FAIL fair_onehot[%0d] got=%h exp=%h", i, oh, 8'h01 << e); end
            n_cmp++; if (multi !== 1'b1) begin n_err++; $display("FAIL fair_multi[%0d] got=%0b exp=1", i, multi); end
        end
        req = '0; rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h0C; rdy = 1'b0;
        tick();
        n_cmp++; if (idx !== 3'd2)   begin n_err++; $display("FAIL bp_capture_idx got=%0d exp=2", idx); end
        req = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (vld !== 1'b1)   begin n_err++; $display("FAIL bp_hold_valid[%0d] got=%0b exp=1", i, vld); end
            n_cmp++; if (idx !== 3'd2)   begin n_err++; $display("FAIL bp_hold_idx[%0d] got=%0d exp=2", i, idx); end
            n_cmp++; if (oh !== 8'h04)   begin n_err++; $display("FAIL bp_hold_onehot[%0d] got=%h exp=04", i, oh); end
            n_cmp++; if (multi !== 1'b1) begin n_err++; $display("FAIL bp_hold_multi[%0d] got=%0b exp=1", i, multi); end
        end
        rdy = 1'b1;
        tick();
        n_cmp++; if (vld !== 1'b1)   begin n_err++; $display("FAIL bp_next_valid got=%0b exp=1", vld); end
        n_cmp++; if (idx !== 3'd0)   begin n_err++; $display("FAIL bp_next_idx got=%0d exp=0", idx); end
        n_cmp++; if (multi !== 1'b0) begin n_err++; $display("FAIL bp_next_multi got=%0b exp=0", multi); end
        // after accepting idx 0, ptr=1: req 0x03 -> 1 is ahead of 0
        req = 8'h03;
        tick();
        n_cmp++; if (idx !== 3'd1)   begin n_err++; $display("FAIL bp_rot_idx got=%0d exp=1", idx); end
        req = '0; rdy = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 8'h20; rdy = 1'b0;
        tick();
        n_cmp++; if (idx !== 3'd5) begin n_err++; $display("FAIL rmh_setup_idx got=%0d exp=5", idx); end
        req = 8'hFF;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (vld !== 1'b0)   begin n_err++; $display("FAIL rmh_valid got=%0b exp=0", vld); end
        n_cmp++; if (idx !== 3'd0)   begin n_err++; $display("FAIL rmh_idx got=%0d exp=0", idx); end
        n_cmp++; if (oh !== 8'h00)   begin n_err++; $display("FAIL rmh_onehot got=%h exp=00", oh); end
        n_cmp++; if (multi !== 1'b0) begin n_err++; $display("FAIL rmh_multi got=%0b exp=0", multi); end
        #1 rst = 1'b0;
        tick();
        n_cmp++; if (idx !== 3'd0)   begin n_err++; $display("FAIL rmh_first_idx got=%0d exp=0", idx); end
        n_cmp++; if (vld !== 1'b1)   begin n_err++; $display("FAIL rmh_first_valid got=%0b exp=1", vld); end
        req = '0;
    endtask

    task automatic test_wrap_n5();
        do_reset();
        req5 = 5'b10000;
        tick();
        n_cmp++; if (idx5 !== 3'd4) begin n_err++; $display("FAIL wrap5_setup_idx got=%0d exp=4", idx5); end
        req5 = 5'b10001; rdy5 = 1'b1;
        tick();
        n_cmp++; if (idx5 !== 3'd0)     begin n_err++; $display("FAIL wrap5_idx got=%0d exp=0", idx5); end
        n_cmp++; if (oh5 !== 5'b00001)  begin n_err++; $display("FAIL wrap5_onehot got=%b exp=00001", oh5); end
        n_cmp++; if (multi5 !== 1'b1)   begin n_err++; $display("FAIL wrap5_multi got=%0b exp=1", multi5); end
        tick();
        n_cmp++; if (idx5 !== 3'd4)     begin n_err++; $display("FAIL wrap5_rot_idx got=%0d exp=4", idx5); end
        tick();
        n_cmp++; if (idx5 !== 3'd0)     begin n_err++; $display("FAIL wrap5_rot2_idx got=%0d exp=0", idx5); end
        req5 = '0; rdy5 = 1'b0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req = 8'b1010_0110; rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (idx !== 3'd7)   begin n_err++; $display("FAIL fixed_idx[%0d] got=%0d exp=7", i, idx); end
            n_cmp++; if (vld !== 1'b1)   begin n_err++; $display("FAIL fixed_valid[%0d] got=%0b exp=1", i, vld); end
            n_cmp++; if (multi !== 1'b1) begin n_err++; $display("FAIL fixed_multi[%0d] got=%0b exp=1", i, multi); end
        end
        req = 8'b0000_0110;
        tick();
        n_cmp++; if (idx !== 3'd2) begin n_err++; $display("FAIL fixed_low_idx got=%0d exp=2", idx); end
        req = '0; rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef FIXED_PRIORITY_EN
        test_fixed_priority();
`else
        test_fairness();
        test_backpressure();
        test_reset_mid_hold();
        test_wrap_n5();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
